count_check_cw8: RTL

Stream-side counterpart to the count-cycle framer. It accepts a data stream tagged with an 8-bit count and a final-count flag and checks that the counts step 0..cnt_limit and wrap correctly. It turns the final-count flag into AXI-Stream tlast and drops beats that are out of sequence until it re-locks. It sits at the consumer end of the channelizer test path and reports sequence health through sticky counters and a per-error pulse.

---
 rtl/count_cycle_pkg.sv | 31 +++
 rtl/axi_skid_buf.sv | 52 +++++
 rtl/count_check_cw8.sv | 95 +++++++++
 3 files changed

// File: rtl/count_cycle_pkg.sv
// Shared types and helpers for the count-cycle framer/checker pair.
// The beat layout must stay in step with the framer side.
package count_cycle_pkg;

    localparam int CNT_WIDTH = 8;
    localparam int BEAT_DATA_WIDTH = 32;
    localparam logic [15:0] SAT16_MAX = 16'hFFFF;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    typedef struct packed {
        logic                       final_cnt;
        logic [CNT_WIDTH-1:0]       count;
        logic [BEAT_DATA_WIDTH-1:0] data;
    } beat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == SAT16_MAX) ? value : value + 16'd1;
    endfunction

    // The flag must mark exactly the limit count, and no count may exceed the limit.
    function automatic logic beat_consistent(input logic [CNT_WIDTH-1:0] count,
                                             input logic                 final_cnt,
                                             input logic [CNT_WIDTH-1:0] lim);
        return (final_cnt == (count == lim)) && (count <= lim);
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry output stage: an output register plus one skid register that
// absorbs the beat arriving in the cycle the downstream stalls.
module axi_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             alive;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             out_load;

    // alive keeps ready low until the first edge after reset release.
    assign in_ready = alive && !skid_valid;
    assign out_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            alive <= 1'b1;
            if (out_load) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_data <= in_data;
                    end
                end
            end else if (in_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/count_check_cw8.sv
// Sequence checker for count-tagged streams: verifies 0..cnt_limit stepping,
// drops out-of-sequence beats until relock, and maps final_cnt onto tlast.
module count_check_cw8
    import count_cycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CNT_WIDTH-1:0]  s_axis_count,
    input  logic                  s_axis_final_cnt,
    output logic                  s_axis_tready,
    input  logic [CNT_WIDTH-1:0]  cnt_limit,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  seq_err,
    output logic                  in_sync,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
);

    chk_state_t           state, state_nxt;
    logic [CNT_WIDTH-1:0] expected, expected_nxt;
    logic [CNT_WIDTH-1:0] lim_d0;
    logic                 accept, consistent, hunt_ok, fwd, err;

    always_ff @(posedge clk) begin
        lim_d0 <= cnt_limit;
    end

    assign accept     = s_axis_tvalid && s_axis_tready;
    assign consistent = beat_consistent(s_axis_count, s_axis_final_cnt, lim_d0);
    assign hunt_ok    = consistent && (s_axis_count == '0);
    assign in_sync    = (state == LOCKED);

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        fwd          = 1'b0;
        err          = 1'b0;
        if (accept) begin
            if (state == LOCKED && consistent && s_axis_count == expected) begin
                fwd          = 1'b1;
                expected_nxt = s_axis_final_cnt ? '0 : s_axis_count + 8'd1;
            end else begin
                // A failing beat in LOCKED falls through to the HUNT rule in the same cycle.
                err       = (state == LOCKED);
                state_nxt = HUNT;
                if (hunt_ok) begin
                    fwd          = 1'b1;
                    state_nxt    = LOCKED;
                    expected_nxt = s_axis_final_cnt ? '0 : 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            expected  <= '0;
            seq_err   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
            seq_err  <= err;
            if (err) begin
                err_cnt <= sat_inc16(err_cnt);
            end
            if (fwd && s_axis_final_cnt) begin
                frame_cnt <= sat_inc16(frame_cnt);
            end
        end
    end

    axi_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (fwd),
        .in_data  ({s_axis_final_cnt, s_axis_tdata}),
        .in_ready (s_axis_tready),
        .out_valid(m_axis_tvalid),
        .out_data ({m_axis_tlast, m_axis_tdata}),
        .out_ready(m_axis_tready)
    );

endmodule
